// File: rtl/prim_arb_rsp_router.sv
// Return-path router for the N:1 round-robin arbiter: in-order ID FIFO plus a 1:N response demux.
// Optional same-cycle fall-through on an empty FIFO: define PRIM_ARB_RSP_ROUTER_BYPASS_EN.

// Per-requester routing slice: claims the response when the selected index matches this lane.
module prim_arb_rsp_router_lane #(
    parameter int unsigned IdxW = 3,
    parameter int unsigned Lane = 0
) (
    input  logic [IdxW-1:0] idx,
    input  logic            en,
    input  logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            lane_valid,
    output logic            lane_ready
);
    logic sel;

    assign sel        = en && (idx == IdxW'(Lane));
    assign lane_valid = sel & rsp_valid;
    assign lane_ready = sel & rsp_ready;
endmodule

module prim_arb_rsp_router #(
    parameter  int unsigned N     = 8,
    parameter  int unsigned DW    = 32,
    parameter  int unsigned Depth = 4,
    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_valid_i,
    input  logic [IdxW-1:0] push_idx_i,
    output logic            push_ready_o,
    input  logic            rsp_valid_i,
    input  logic [DW-1:0]   rsp_data_i,
    output logic            rsp_ready_o,
    output logic [N-1:0]    rsp_valid_o,
    output logic [DW-1:0]   rsp_data_o,
    input  logic [N-1:0]    rsp_ready_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_o,
    input  logic            clr_err_i
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Depth-1:0][IdxW-1:0] mem_q;
    logic [PtrW-1:0]            wptr_q, rptr_q;
    logic [CntW-1:0]            cnt_q;
    logic                       err_q;

    logic            empty, byp, route_act, in_range;
    logic [IdxW-1:0] head, route_idx;
    logic [N-1:0]    lane_valid, lane_ready;
    logic            rsp_fire, wr_en, rd_en, err_set;

    // Non-power-of-2 Depth needs an explicit wrap instead of natural overflow.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty         = (cnt_q == '0);
    assign head          = mem_q[rptr_q];
    assign push_ready_o  = (cnt_q != CntW'(Depth));
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;
    assign rsp_data_o    = rsp_data_i;

`ifdef PRIM_ARB_RSP_ROUTER_BYPASS_EN
    assign byp = empty & push_valid_i & rsp_valid_i;
`else
    assign byp = 1'b0;
`endif

    assign route_act = ~empty | byp;
    assign route_idx = byp ? push_idx_i : head;
    assign in_range  = ({1'b0, route_idx} < (IdxW + 1)'(N));

    for (genvar i = 0; i < N; i++) begin : g_lane
        prim_arb_rsp_router_lane #(
            .IdxW (IdxW),
            .Lane (i)
        ) u_lane (
            .idx        (route_idx),
            .en         (route_act & in_range),
            .rsp_valid  (rsp_valid_i),
            .rsp_ready  (rsp_ready_i[i]),
            .lane_valid (lane_valid[i]),
            .lane_ready (lane_ready[i])
        );
    end

    assign rsp_valid_o = lane_valid;

    // Responses with nowhere to go (empty FIFO or bad index) are sunk so the sink never stalls.
    always_comb begin
        rsp_ready_o = rsp_valid_i;
        if (route_act) begin
            rsp_ready_o = in_range ? |lane_ready : 1'b1;
        end
    end

    assign rsp_fire = rsp_valid_i & rsp_ready_o;
    assign wr_en    = push_valid_i & push_ready_o & ~(byp & rsp_fire);
    assign rd_en    = rsp_fire & ~empty;
    assign err_set  = rsp_valid_i & ~(route_act & in_range);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= push_idx_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (rd_en) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (clr_err_i) begin
            err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prim_arb_rsp_router.sv
// Bench for prim_arb_rsp_router: vector table plus scoreboard on the default build,
// a Depth=3/N=5 instance for pointer wrap and out-of-range indices.
module tb_prim_arb_rsp_router;
    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    // default instance: N=8, DW=32, Depth=4
    logic        pv, rv, clr;
    logic [2:0]  pidx;
    logic [31:0] rdata, dout;
    logic [7:0]  rrdy, vo;
    logic        pr, ro, err;
    logic [2:0]  cnt;

    prim_arb_rsp_router u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .push_valid_i(pv), .push_idx_i(pidx), .push_ready_o(pr),
        .rsp_valid_i(rv), .rsp_data_i(rdata), .rsp_ready_o(ro),
        .rsp_valid_o(vo), .rsp_data_o(dout), .rsp_ready_i(rrdy),
        .outstanding_o(cnt), .err_o(err), .clr_err_i(clr)
    );

    // small instance: N=5 (IdxW=3), Depth=3 (CntW=2)
    logic        pv3, rv3, clr3, pr3, ro3, err3;
    logic [2:0]  pidx3;
    logic [31:0] rdata3, dout3;
    logic [4:0]  rrdy3, vo3;
    logic [1:0]  cnt3;

    prim_arb_rsp_router #(.N(5), .DW(32), .Depth(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_ni),
        .push_valid_i(pv3), .push_idx_i(pidx3), .push_ready_o(pr3),
        .rsp_valid_i(rv3), .rsp_data_i(rdata3), .rsp_ready_o(ro3),
        .rsp_valid_o(vo3), .rsp_data_o(dout3), .rsp_ready_i(rrdy3),
        .outstanding_o(cnt3), .err_o(err3), .clr_err_i(clr3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    // Every accepted response must go to the oldest outstanding requester with its data.
    always @(negedge clk) begin
        if (rst_ni) begin
            logic [7:0] one;
            one = 8'd1;
            chk("onehot0", {63'd0, $onehot0(vo)}, 64'd1);
            if (|(vo & rrdy)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", {56'd0, vo}, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_valid", {56'd0, vo}, {56'd0, one << e.idx});
                    chk("sb_data", {32'd0, dout}, {32'd0, e.data});
                end
            end
        end
    end

    typedef struct {
        logic        pv;
        logic [2:0]  pidx;
        logic [31:0] tag;
        logic        rv;
        logic [31:0] rdata;
        logic [7:0]  rrdy;
        logic [7:0]  e_vo;
        logic        e_ro;
        logic [2:0]  e_cnt;
        logic        e_pr;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [2:0] i, input logic [31:0] t,
                                input logic r, input logic [31:0] d, input logic [7:0] rd,
                                input logic [7:0] evo, input logic ero, input logic [2:0] ec,
                                input logic epr);
        vec_t v;
        v.pv = p; v.pidx = i; v.tag = t; v.rv = r; v.rdata = d; v.rrdy = rd;
        v.e_vo = evo; v.e_ro = ero; v.e_cnt = ec; v.e_pr = epr;
        return v;
    endfunction

    vec_t tbl[20];
    int   q3[$];

    initial begin
        tbl[0]  = mk(1, 3, 32'hA,  0, 0,      8'h00, 8'h00, 0, 0, 1);
        tbl[1]  = mk(1, 5, 32'hB,  0, 0,      8'h00, 8'h00, 0, 1, 1);
        tbl[2]  = mk(1, 1, 32'hC,  0, 0,      8'h00, 8'h00, 0, 2, 1);
        tbl[3]  = mk(0, 0, 0,      1, 32'hA,  8'hFF, 8'h08, 1, 3, 1);
        tbl[4]  = mk(0, 0, 0,      1, 32'hB,  8'hFF, 8'h20, 1, 2, 1);
        tbl[5]  = mk(0, 0, 0,      1, 32'hC,  8'hFF, 8'h02, 1, 1, 1);
        tbl[6]  = mk(0, 0, 0,      0, 0,      8'h00, 8'h00, 0, 0, 1);
        tbl[7]  = mk(1, 0, 32'hD0, 0, 0,      8'h00, 8'h00, 0, 0, 1);
        tbl[8]  = mk(1, 2, 32'hD1, 0, 0,      8'h00, 8'h00, 0, 1, 1);
        tbl[9]  = mk(1, 4, 32'hD2, 0, 0,      8'h00, 8'h00, 0, 2, 1);
        tbl[10] = mk(1, 7, 32'hD3, 0, 0,      8'h00, 8'h00, 0, 3, 1);
        tbl[11] = mk(1, 5, 32'hEE, 0, 0,      8'h00, 8'h00, 0, 4, 0);
        tbl[12] = mk(0, 0, 0,      1, 32'hD0, 8'hFF, 8'h01, 1, 4, 0);
        tbl[13] = mk(0, 0, 0,      0, 0,      8'h00, 8'h00, 0, 3, 1);
        tbl[14] = mk(1, 6, 32'hD4, 1, 32'hD1, 8'hFF, 8'h04, 1, 3, 1);
        tbl[15] = mk(0, 0, 0,      0, 0,      8'h00, 8'h00, 0, 3, 1);
        tbl[16] = mk(0, 0, 0,      1, 32'hD2, 8'hFF, 8'h10, 1, 3, 1);
        tbl[17] = mk(0, 0, 0,      1, 32'hD3, 8'hFF, 8'h80, 1, 2, 1);
        tbl[18] = mk(0, 0, 0,      1, 32'hD4, 8'hFF, 8'h40, 1, 1, 1);
        tbl[19] = mk(0, 0, 0,      0, 0,      8'h00, 8'h00, 0, 0, 1);

        rst_ni = 1'b0;
        pv = 0; pidx = 0; rv = 0; rdata = 0; rrdy = 0; clr = 0;
        pv3 = 0; pidx3 = 0; rv3 = 0; rdata3 = 0; rrdy3 = 0; clr3 = 0;
        #12;
        chk("rst_cnt", cnt, 0);
        chk("rst_push_ready", pr, 1);
        chk("rst_rsp_valid", vo, 0);
        chk("rst_rsp_ready", ro, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt3", cnt3, 0);
        rst_ni = 1'b1;
        step();

        // in-order routing, full back-pressure, push+pop at count 3
        for (int i = 0; i < 20; i++) begin
            pv = tbl[i].pv; pidx = tbl[i].pidx; rv = tbl[i].rv;
            rdata = tbl[i].rdata; rrdy = tbl[i].rrdy;
            #1;
            chk($sformatf("tbl%0d_vo", i), vo, tbl[i].e_vo);
            chk($sformatf("tbl%0d_ro", i), ro, tbl[i].e_ro);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_pr", i), pr, tbl[i].e_pr);
            if (tbl[i].pv && tbl[i].e_pr) sb.push_back('{tbl[i].pidx, tbl[i].tag});
            step();
        end
        pv = 0; rv = 0; rrdy = 0;
        chk("tbl_err", err, 0);

        // head stalls while its requester is not ready
        pv = 1; pidx = 2; sb.push_back('{3'd2, 32'h22});
        step();
        pv = 0; rv = 1; rdata = 32'h22; rrdy = 8'hFB;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_vo", vo, 8'h04);
            chk("hold_ro", ro, 0);
            chk("hold_cnt", cnt, 1);
            step();
        end
        rrdy = 8'hFF;
        #1;
        chk("hold_release_ro", ro, 1);
        step();
        rv = 0;
        #1;
        chk("hold_pop_cnt", cnt, 0);

        // response on empty FIFO is dropped and flagged; set beats clear
        rv = 1; rdata = 32'hDEAD;
        #1;
        chk("empty_ro", ro, 1);
        chk("empty_vo", vo, 0);
        step();
        chk("empty_err_set", err, 1);
        chk("empty_cnt", cnt, 0);
        clr = 1;
        step();
        chk("err_set_over_clr", err, 1);
        rv = 0;
        step();
        clr = 0;
        chk("err_clr", err, 0);

        // reset mid-operation discards stored IDs
        pv = 1; pidx = 1; step();
        pidx = 2; step();
        pv = 0;
        chk("pre_rst_cnt", cnt, 2);
        rst_ni = 0;
        #1;
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_pr", pr, 1);
        step();
        rst_ni = 1;
        step();

        // empty FIFO with push and response in the same cycle
        pv = 1; pidx = 6; rv = 1; rdata = 32'h66; rrdy = 8'hFF;
`ifdef PRIM_ARB_RSP_ROUTER_BYPASS_EN
        sb.push_back('{3'd6, 32'h66});
        #1;
        chk("byp_vo", vo, 8'h40);
        chk("byp_ro", ro, 1);
        step();
        pv = 0; rv = 0;
        #1;
        chk("byp_cnt", cnt, 0);
        chk("byp_err", err, 0);
`else
        #1;
        chk("nobyp_vo", vo, 0);
        chk("nobyp_ro", ro, 1);
        step();
        pv = 0;
        chk("nobyp_cnt", cnt, 1);
        chk("nobyp_err", err, 1);
        sb.push_back('{3'd6, 32'h67});
        rdata = 32'h67;
        #1;
        chk("nobyp_drain_vo", vo, 8'h40);
        step();
        rv = 0; clr = 1;
        chk("nobyp_drain_cnt", cnt, 0);
        step();
        clr = 0;
        chk("nobyp_err_clr", err, 0);
`endif

        // Depth=3 pointer wrap: keep two outstanding, push one and pop one per round
        rrdy3 = 5'h1F;
        for (int i = 0; i < 2; i++) begin
            pv3 = 1; pidx3 = 3'($urandom_range(0, 4)); q3.push_back(int'(pidx3));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            pv3 = 1; pidx3 = 3'($urandom_range(0, 4)); rv3 = 1;
            #1;
            chk($sformatf("wrap%0d_vo", i), vo3, 5'd1 << q3[0]);
            chk($sformatf("wrap%0d_cnt", i), cnt3, 2);
            chk($sformatf("wrap%0d_pr", i), pr3, 1);
            void'(q3.pop_front());
            q3.push_back(int'(pidx3));
            step();
        end
        pv3 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("drain%0d_vo", i), vo3, 5'd1 << q3[0]);
            void'(q3.pop_front());
            step();
        end
        rv3 = 0;
        #1;
        chk("drain_cnt3", cnt3, 0);

        // index beyond N at the head: response dropped, entry popped, error flagged
        pv3 = 1; pidx3 = 3'd6;
        step();
        pv3 = 0; rv3 = 1;
        #1;
        chk("oor_vo", vo3, 0);
        chk("oor_ro", ro3, 1);
        chk("oor_err_before", err3, 0);
        step();
        rv3 = 0;
        chk("oor_err", err3, 1);
        chk("oor_cnt", cnt3, 0);

        step();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
